// File: rtl/t_pulse_gen_if.sv
// Handshake/control bundle between a sequencer and t_pulse_gen.
// Optional q_model output appears when T_PULSE_GEN_QMODEL_EN is defined.
interface t_pulse_gen_if #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
);
    logic               start;
    logic               stop;
    logic [CNT_W-1:0]   period;
    logic [BURST_W-1:0] burst;
    logic               t;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] pulse_cnt;
`ifdef T_PULSE_GEN_QMODEL_EN
    logic               q_model;

    modport master (
        output start, stop, period, burst,
        input  t, busy, done, pulse_cnt, q_model
    );
    modport slave (
        input  start, stop, period, burst,
        output t, busy, done, pulse_cnt, q_model
    );
`else
    modport master (
        output start, stop, period, burst,
        input  t, busy, done, pulse_cnt
    );
    modport slave (
        input  start, stop, period, burst,
        output t, busy, done, pulse_cnt
    );
`endif
endinterface

// File: rtl/t_pulse_gen.sv
// Programmable toggle-enable generator feeding a T flip-flop's t input.
// Define T_PULSE_GEN_QMODEL_EN to add the q_model mirror of the downstream FF.
module t_pulse_gen #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    t_pulse_gen_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nxt;
    logic [CNT_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_per;
    logic [BURST_W-1:0] r_bst;
    logic [BURST_W-1:0] r_cnt;
    logic               r_t;
    logic               r_done;
    logic               w_hit;
    logic               w_last;
    logic               w_accept;
    logic               w_busy;

    assign w_hit  = (r_div == r_per - CNT_W'(1));
    assign w_last = (r_bst != '0) &&
                    (r_cnt + BURST_W'(1) == r_bst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    w_nxt = S_IDLE;
                end else if (w_hit && w_last) begin
                    w_nxt = S_DONE;
                end
            end
            S_DONE:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_busy   = 1'b0;
        unique case (r_state)
            S_IDLE:  w_accept = bus.start && !bus.stop;
            S_RUN:   w_busy   = 1'b1;
            S_DONE:  w_busy   = 1'b1;
            default: w_busy   = 1'b0;
        endcase
    end

    // Divider, pulse register and counters follow the FSM decisions above
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_per  <= CNT_W'(1);
            r_bst  <= '0;
            r_cnt  <= '0;
            r_t    <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            unique case (r_state)
                S_IDLE: begin
                    r_t <= 1'b0;
                    if (w_accept) begin
                        r_per <= (bus.period == '0) ? CNT_W'(1)
                                                    : bus.period;
                        r_bst <= bus.burst;
                        r_div <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        r_t   <= 1'b0;
                        r_div <= '0;
                    end else if (w_hit) begin
                        r_t   <= 1'b1;
                        r_div <= '0;
                        r_cnt <= r_cnt + BURST_W'(1);
                    end else begin
                        r_t   <= 1'b0;
                        r_div <= r_div + CNT_W'(1);
                    end
                end
                S_DONE:  r_t <= 1'b0;
                default: r_t <= 1'b0;
            endcase
        end
    end

`ifdef T_PULSE_GEN_QMODEL_EN
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (r_t) begin
            r_q <= ~r_q;
        end
    end

    assign bus.q_model = r_q;
`endif

    assign bus.t         = r_t;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.pulse_cnt = r_cnt;

endmodule

// File: tb/tb_t_pulse_gen.sv
// Directed plus randomized bench for t_pulse_gen against a closed-form model.
// Pulse timing is predicted from the accept edge, period and burst arithmetic.
module tb_t_pulse_gen;

    logic clk;
    logic rst_n;

    t_pulse_gen_if #(.CNT_W(8), .BURST_W(8)) bus ();
    t_pulse_gen_if #(.CNT_W(8), .BURST_W(2)) bus2 ();

    t_pulse_gen #(.CNT_W(8), .BURST_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    t_pulse_gen #(.CNT_W(8), .BURST_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: accept edge, effective period, burst
    bit m_act;
    int cyc;
    int m_k;
    int m_P;
    int m_B;
    bit e_t;
    bit e_busy;
    bit e_done;
    bit e_q;
    int e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act  = 1'b0;
        e_t    = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_q    = 1'b0;
        e_cnt  = 0;
    endtask

    task automatic model_edge(input bit st, input bit sp);
        int d;
        cyc++;
        e_q = e_q ^ e_t;
        if (!m_act) begin
            e_t    = 1'b0;
            e_done = 1'b0;
            e_busy = 1'b0;
            if (st && !sp) begin
                m_act  = 1'b1;
                m_k    = cyc;
                m_P    = (bus.period == 0) ? 1 : int'(bus.period);
                m_B    = int'(bus.burst);
                e_busy = 1'b1;
                e_cnt  = 0;
            end
        end else begin
            d = cyc - m_k;
            if (m_B != 0 && d - 1 == m_B * m_P) begin
                m_act  = 1'b0;
                e_t    = 1'b0;
                e_busy = 1'b0;
                e_done = 1'b1;
            end else if (sp) begin
                m_act  = 1'b0;
                e_t    = 1'b0;
                e_busy = 1'b0;
                e_done = 1'b0;
            end else begin
                e_t    = (d % m_P) == 0;
                e_busy = 1'b1;
                e_done = 1'b0;
                e_cnt  = (d / m_P) % 256;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".t"}, 32'(bus.t), 32'(e_t));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(bus.done), 32'(e_done));
        chk({tag, ".cnt"}, 32'(bus.pulse_cnt), 32'(e_cnt));
`ifdef T_PULSE_GEN_QMODEL_EN
        chk({tag, ".q"}, 32'(bus.q_model), 32'(e_q));
`endif
    endtask

    task automatic step(input string tag, input bit st, input bit sp);
        @(negedge clk);
        bus.start = st;
        bus.stop  = sp;
        @(posedge clk);
        model_edge(st, sp);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.period  = '0;
        bus.burst   = '0;
        bus2.start  = 1'b0;
        bus2.stop   = 1'b0;
        bus2.period = '0;
        bus2.burst  = '0;
        cyc         = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Bounded burst: P=4, B=3
        bus.period = 8'd4;
        bus.burst  = 8'd3;
        step("burst_start", 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step("burst", 1'b0, 1'b0);
        chk("burst_cnt_held", 32'(bus.pulse_cnt), 32'd3);

        // Period 0 behaves as 1
        bus.period = 8'd0;
        bus.burst  = 8'd5;
        step("p0_start", 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step("p0", 1'b0, 1'b0);

        // Stop landing on a pulse edge
        bus.period = 8'd2;
        bus.burst  = 8'd0;
        step("stop_start", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("stop_run", 1'b0, 1'b0);
        step("stop_hit", 1'b0, 1'b1);
        step("stop_after", 1'b0, 1'b0);

        // Start while running, then start+stop while idle
        bus.period = 8'd3;
        bus.burst  = 8'd2;
        step("ign_start", 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.period = 8'(i + 7);
            bus.burst  = 8'(i);
            step("ign_run", 1'b1, 1'b0);
        end
        bus.period = 8'd3;
        for (int i = 0; i < 4; i++) step("ign_tail", 1'b0, 1'b0);
        step("ign_both", 1'b1, 1'b1);
        step("ign_both2", 1'b1, 1'b1);
        step("ign_idle", 1'b0, 1'b0);

        // Randomized sequences
        for (int i = 0; i < 400; i++) begin
            bus.period = 8'($urandom_range(0, 5));
            bus.burst  = 8'($urandom_range(0, 4));
            step("rand", $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0);
        end
        step("rand_stop", 1'b0, 1'b1);
        step("rand_idle", 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run
        bus.period = 8'd3;
        bus.burst  = 8'd0;
        step("rst_start", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("rst_run", 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async.t", 32'(bus.t), 32'd0);
        chk("rst_async.busy", 32'(bus.busy), 32'd0);
        chk("rst_async.cnt", 32'(bus.pulse_cnt), 32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("rst_idle", 1'b0, 1'b0);

        // Counter wrap on a 2-bit burst width
        @(negedge clk);
        bus2.period = 8'd1;
        bus2.burst  = 2'd0;
        bus2.start  = 1'b1;
        @(negedge clk);
        bus2.start  = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            chk("wrap.cnt", 32'(bus2.pulse_cnt), 32'(i % 4));
            chk("wrap.t", 32'(bus2.t), 32'd1);
        end
        @(negedge clk);
        bus2.stop = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap_stop.busy", 32'(bus2.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/t_pulse_gen.md
# t_pulse_gen

- Programmable toggle-enable generator sitting directly upstream of the T flip-flop; its `t` output drives the T FF's `t` input.
- After a start request, asserts `t` for one cycle every `period` cycles, for a bounded burst or continuously, until stopped.
- Provides busy/done status and a pulse count, so control logic and benches can sequence toggle activity without hand-timed stimulus.

## Interface
- `CNT_W`, default 8: width of `period` and of the internal divider counter.
- `BURST_W`, default 8: width of `burst` and `pulse_cnt`.

- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request to begin; sampled only in IDLE.
- `stop`  in  1  abort request; sampled in RUN.
- `period`  in  CNT_W  cycles between `t` pulses; latched on start accept; 0 is treated as 1.
- `burst`  in  BURST_W  number of pulses; latched on start accept; 0 means continuous.
- `t`  out  1  toggle enable to the T FF; registered.
- `busy`  out  1  high while in RUN or DONE.
- `done`  out  1  one-cycle pulse on burst completion.
- `pulse_cnt`  out  BURST_W  pulses issued since the last start accept.

## Operation
- **States**
  - IDLE: `t`=0.
  - RUN: dividing.
  - DONE: one-cycle completion state.
- **IDLE → RUN**
  - Taken on an edge with `start`=1 and `stop`=0.
  - On that edge: latch `per` = max(`period`, 1) and `bst` = `burst`; clear `div` and `pulse_cnt`.
- **RUN, each edge (this priority order)**
  1. `stop`=1: `t`<=0, `div`<=0, go to IDLE. No `done`; `pulse_cnt` holds.
  2. `div`==`per`-1: `div`<=0, `t`<=1, `pulse_cnt`<=`pulse_cnt`+1.
     - If `bst`!=0 and `pulse_cnt`+1==`bst`, go to DONE.
  3. Otherwise: `div`<=`div`+1, `t`<=0.
- **DONE, next edge:** `t`<=0, `done`<=1, go to IDLE.
- **`done`:** cleared on the following edge; strictly one cycle wide.
- **Continuous mode (`bst`=0):** `pulse_cnt` wraps modulo 2^BURST_W; no DONE.
- **`period`=1:** `t` stays high every RUN cycle, i.e. the downstream FF toggles every clock.
- **`start` while busy:** ignored. `period`/`burst` changes during RUN have no effect.
- **`start` and `stop` together in IDLE:** `stop` wins; stays IDLE.
- **Widths:** `div` is CNT_W bits. `per`-1 never underflows because `per` >= 1.

## Timing
- **Reset values (asserted asynchronously, mid-operation included):**
  - `t`=0, `busy`=0, `done`=0, `pulse_cnt`=0.
  - State IDLE; `div`=0, `per`=1, `bst`=0.
- **Start accepted at edge k:**
  - `busy` high from edge k.
  - First `t` high from edge k+P for one cycle (P = effective period).
  - Subsequent pulses at k+2P, k+3P, …
- **Burst of B pulses:**
  - Last `t` high from edge k+B·P.
  - DONE entered at k+B·P; `done` high from edge k+B·P+1 for one cycle.
  - `busy` low from edge k+B·P+1.
- **Stop sampled at edge s:** `t` and `busy` low from edge s.
- **Restart:** earliest new start accept is the edge after IDLE is re-entered.

## Configuration
- Macro `T_PULSE_GEN_QMODEL_EN`.
- **Defined:** adds output `q_model` (1 bit).
  - Reset 0.
  - Inverts on every edge where `t`=1, mirroring the downstream T FF's `q`, for self-checking benches.
- **Undefined:** port and logic absent; all other behaviour is identical.

## Test plan
- **Reset mid-run:** `period`=3, `burst`=0, start, then `rst_n`=0 between edges.
  - → `t`, `busy`, `pulse_cnt` go to 0 immediately.
  - → Remains IDLE after release until a new start.
- **Bounded burst:** `period`=4, `burst`=3, start at edge k.
  - → `t`=1 only in the cycles after edges k+4, k+8, k+12.
  - → `done`=1 only after k+13; `pulse_cnt`=3 held.
  - → `busy` low from k+13.
- **Period 0/1:** `period`=0, `burst`=5.
  - → `t` high for 5 consecutive cycles, `done` on the 6th.
  - → With QMODEL enabled, `q_model` ends at 1.
- **Stop:** `period`=2, `burst`=0, stop asserted on the cycle `div`==1.
  - → No `t` pulse that cycle; `t`=0, `busy`=0, no `done`, `pulse_cnt` unchanged.
- **Ignored inputs:** `start` while RUN, and `start`+`stop` together in IDLE.
  - → No restart, no counter clear; stays IDLE in the second case.
- **Wrap:** BURST_W=2, `period`=1, `burst`=0, run 6 cycles.
  - → `pulse_cnt` sequence 1, 2, 3, 0, 1, 2; `t` continuously 1.
